// File: rtl/dice_pkg.sv
// Shared types and constants for the dice game controller.
// Optional build macro used by the top: DICE_SCORE_EN (win/loss counters).
package dice_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPIN  = 3'd1,
    LATCH = 3'd2,
    EVAL  = 3'd3,
    POINT = 3'd4,
    WIN   = 3'd5,
    LOSE  = 3'd6
  } state_e;

  localparam logic [2:0] FACE_MIN   = 3'd1;
  localparam logic [2:0] FACE_MAX   = 3'd6;
  localparam logic [3:0] NATURAL_7  = 4'd7;
  localparam logic [3:0] NATURAL_11 = 4'd11;
  localparam logic [3:0] CRAPS_2    = 4'd2;
  localparam logic [3:0] CRAPS_3    = 4'd3;
  localparam logic [3:0] CRAPS_12   = 4'd12;

  // A face outside 1..6 means a broken roller.
  function automatic logic face_ok(input logic [2:0] face);
    return (face >= FACE_MIN) && (face <= FACE_MAX);
  endfunction

endpackage

// File: rtl/dice_roll_classify.sv
// Craps rule table: classifies a latched sum as win, lose or point.
module dice_roll_classify
  import dice_pkg::*;
(
  input  logic [3:0] sum,
  input  logic [3:0] point,
  input  logic       come_out,
  output logic       is_win,
  output logic       is_lose,
  output logic       is_point
);

  always_comb begin
    is_win   = 1'b0;
    is_lose  = 1'b0;
    is_point = 1'b0;
    if (come_out) begin
      if (sum == NATURAL_7 || sum == NATURAL_11)
        is_win = 1'b1;
      else if (sum == CRAPS_2 || sum == CRAPS_3 || sum == CRAPS_12)
        is_lose = 1'b1;
      else
        is_point = 1'b1;
    end else begin
      // Making the point takes priority; a point can never be 7 anyway.
      if (sum == point)
        is_win = 1'b1;
      else if (sum == NATURAL_7)
        is_lose = 1'b1;
      else
        is_point = 1'b1;
    end
  end

endmodule

// File: rtl/dice_game_ctrl.sv
// Craps game sequencer driving a pair of dice rollers.
// Build option DICE_SCORE_EN adds saturating wins/losses counters.
module dice_game_ctrl
  import dice_pkg::*;
#(
  parameter int unsigned MIN_SPIN = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       roll,
  input  logic [2:0] dice_a,
  input  logic [2:0] dice_b,
  output logic       roll_ena,
  output logic [3:0] sum,
  output logic [3:0] point,
  output logic       win,
  output logic       lose,
  output logic       busy,
  output logic       fault
`ifdef DICE_SCORE_EN
  ,
  output logic [7:0] wins,
  output logic [7:0] losses
`endif
);

  state_e           state;
  logic             come_out;
  logic             roll_q;
  logic             roll_rise;
  logic [CNT_W-1:0] spin_cnt;
  logic             is_win;
  logic             is_lose;
  logic             is_point;

  assign roll_rise = roll & ~roll_q;
  assign roll_ena  = (state == SPIN);
  assign win       = (state == WIN);
  assign lose      = (state == LOSE);
  assign busy      = (state == SPIN) || (state == LATCH) || (state == EVAL);

  dice_roll_classify u_classify (
    .sum      (sum),
    .point    (point),
    .come_out (come_out),
    .is_win   (is_win),
    .is_lose  (is_lose),
    .is_point (is_point)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      come_out <= 1'b1;
      sum      <= 4'd0;
      point    <= 4'd0;
      spin_cnt <= '0;
      fault    <= 1'b0;
      roll_q   <= 1'b0;
`ifdef DICE_SCORE_EN
      wins     <= 8'd0;
      losses   <= 8'd0;
`endif
    end else begin
      roll_q <= roll;
      case (state)
        IDLE: begin
          if (roll_rise) begin
            state    <= SPIN;
            spin_cnt <= '0;
            sum      <= 4'd0;
          end
        end
        SPIN: begin
          if (spin_cnt < CNT_W'(MIN_SPIN))
            spin_cnt <= spin_cnt + CNT_W'(1);
          // Short presses keep spinning until the minimum scramble time is met.
          if (!roll && (spin_cnt >= CNT_W'(MIN_SPIN - 1)))
            state <= LATCH;
        end
        LATCH: begin
          if (!face_ok(dice_a) || !face_ok(dice_b)) begin
            fault    <= 1'b1;
            sum      <= 4'd0;
            come_out <= 1'b1;
            point    <= 4'd0;
            state    <= IDLE;
          end else begin
            sum   <= 4'(dice_a) + 4'(dice_b);
            state <= EVAL;
          end
        end
        EVAL: begin
          if (is_win) begin
            state <= WIN;
`ifdef DICE_SCORE_EN
            if (wins != 8'hFF) wins <= wins + 8'd1;
`endif
          end else if (is_lose) begin
            state <= LOSE;
`ifdef DICE_SCORE_EN
            if (losses != 8'hFF) losses <= losses + 8'd1;
`endif
          end else if (is_point) begin
            if (come_out) begin
              point    <= sum;
              come_out <= 1'b0;
            end
            state <= POINT;
          end
        end
        POINT: begin
          if (roll_rise) begin
            state    <= SPIN;
            spin_cnt <= '0;
          end
        end
        WIN, LOSE: begin
          // Point remains visible until the player starts the next game.
          if (roll_rise) begin
            state    <= SPIN;
            spin_cnt <= '0;
            come_out <= 1'b1;
            point    <= 4'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
